// File: rtl/fixed_point_divider_if.sv
// Start/done handshake and result bus for the sign-magnitude fixed-point divider.
// The master drives the operands; the slave (divider) returns the registered result.
interface fixed_point_divider_if #(
  parameter int unsigned N = 16
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] w;
  logic         busy;
  logic         done;
  logic [N-1:0] out;
  logic         ovf;
  logic         dz;

  modport master (
    output start, a, w,
    input  busy, done, out, ovf, dz
  );

  modport slave (
    input  start, a, w,
    output busy, done, out, ovf, dz
  );
endinterface

// File: rtl/fixed_point_divider.sv
// Sequential sign-magnitude fixed-point divider (out = a / w), restoring algorithm,
// one quotient bit per clock under a start/done handshake. All outputs are registered.
module fixed_point_divider #(
  parameter int unsigned N = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  fixed_point_divider_if.slave bus
);

  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e        state_q;
  logic          sign_q;
  logic [N-1:0]  rem_q;
  logic [N-2:0]  div_q;
  logic [N-2:0]  q_q;
  logic [CntW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          ovf_q;
  logic          dz_q;
  logic [N-1:0]  out_q;

  logic          in_sign;
  logic [N-2:0]  a_mag;
  logic [N-2:0]  w_mag;
  logic [N-1:0]  rem_shl;
  logic [N-1:0]  rem_sub;
  logic [N-1:0]  rem_nxt;
  logic          q_bit;
  logic [N-2:0]  q_nxt;
  logic          last_iter;

  always_comb begin
    in_sign   = bus.a[N-1] ^ bus.w[N-1];
    a_mag     = bus.a[N-2:0];
    w_mag     = bus.w[N-2:0];
    // rem < div < 2^(N-1) always holds, so the N-bit shift never loses a bit.
    rem_shl   = rem_q << 1;
    rem_sub   = rem_shl - {1'b0, div_q};
    q_bit     = rem_shl >= {1'b0, div_q};
    rem_nxt   = q_bit ? rem_sub : rem_shl;
    q_nxt     = (q_q << 1) | {{(N-2){1'b0}}, q_bit};
    last_iter = cnt_q == CntW'(N - 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      rem_q   <= '0;
      div_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sign_q <= in_sign;
            rem_q  <= {1'b0, a_mag};
            div_q  <= w_mag;
            q_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            // Zero divisor wins over overflow; both saturate the magnitude.
            if (w_mag == '0) begin
              dz_q    <= 1'b1;
              ovf_q   <= 1'b0;
              out_q   <= {in_sign, {(N-1){1'b1}}};
              done_q  <= 1'b1;
              state_q <= StDone;
            end else if (a_mag >= w_mag) begin
              dz_q    <= 1'b0;
              ovf_q   <= 1'b1;
              out_q   <= {in_sign, {(N-1){1'b1}}};
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              dz_q    <= 1'b0;
              ovf_q   <= 1'b0;
              out_q   <= '0;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          rem_q <= rem_nxt;
          q_q   <= q_nxt;
          cnt_q <= cnt_q + CntW'(1);
          if (last_iter) begin
            out_q   <= {sign_q, q_nxt};
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;
  assign bus.ovf  = ovf_q;
  assign bus.dz   = dz_q;

endmodule
